mesi_bus_arbiter: RTL
=====================

MESI_BUS_ARBITER -- requirements
Module: mesi_bus_arbiter

Interface
REQ-001 Parameter NUM_CORES, default 4, SHALL set the number of requesting cache controllers (2..8).
REQ-002 Parameter ADDR_W, default 32, SHALL set the bus address width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 req  input  NUM_CORES  SHALL be the per-core bus request, held high until that core's done.
REQ-006 req_cmd  input  2*NUM_CORES  SHALL be the per-core command: 01 BusRd, 10 BusRdX; 00 and 11 are illegal.
REQ-007 req_addr  input  ADDR_W*NUM_CORES  SHALL be the per-core line address.
REQ-008 gnt  output  NUM_CORES  SHALL be one-hot, high for the owning core from ADDR through DONE.
REQ-009 done  output  NUM_CORES  SHALL be a one-cycle completion pulse to the owner.
REQ-010 done_shared  output  1  SHALL be valid with done: 1 means install S, 0 means install E (BusRd) or M (BusRdX).
REQ-011 bus_valid, bus_cmd[1:0], bus_addr[ADDR_W-1:0]  outputs  SHALL drive the snooped bus; bus_cmd is 00 when not valid.
REQ-012 snoop_hit, snoop_dirty  inputs  NUM_CORES each  SHALL be the per-core snooper hit and Modified indications.
REQ-013 mem_req, mem_we  outputs  1 each  SHALL request a memory read (mem_we=0) or writeback (mem_we=1).
REQ-014 mem_ack  input  1  SHALL complete the current memory request.

Function
REQ-015 The FSM SHALL have states IDLE, ADDR, SNOOP, WB, MEM and DONE.
REQ-016 A core SHALL be eligible when req is high and req_cmd is 01 or 10; requests with illegal commands SHALL never be granted.
REQ-017 In IDLE with at least one eligible core, the block SHALL select the first eligible core at or after rr_ptr (modulo NUM_CORES), latch its index, command and address, and enter ADDR.
REQ-018 In ADDR, for exactly one cycle, the block SHALL assert bus_valid with the latched cmd and addr, assert gnt, and enter SNOOP.
REQ-019 In SNOOP, the block SHALL sample snoop_hit and snoop_dirty once, masking the owner's bit.
REQ-020 The shared flag SHALL be the OR of the other cores' hits when the command is BusRd, and 0 when it is BusRdX.
REQ-021 Any other core's dirty bit SHALL select WB; otherwise the block SHALL go to MEM.
REQ-022 In WB, the block SHALL hold mem_req=1 and mem_we=1 with no timeout until mem_ack, then enter MEM.
REQ-023 In MEM, the block SHALL hold mem_req=1 and mem_we=0 until mem_ack, then enter DONE.
REQ-024 In DONE, the block SHALL pulse done[owner] for one cycle with done_shared, set rr_ptr to (owner+1) mod NUM_CORES, and return to IDLE.
REQ-025 mem_ack outside WB/MEM SHALL be ignored; mem_ack in the same cycle the request is first asserted SHALL be accepted.
REQ-026 Minimum latency SHALL be 5 cycles from req sampled in IDLE to done, plus memory waits.
REQ-027 Deassertion of the owner's req mid-transaction SHALL NOT abort it; done still pulses.
REQ-028 Requests arriving during a transaction SHALL wait; there is exactly one transaction outstanding.
REQ-029 A core that re-requests in the cycle after its own DONE SHALL be lowest priority relative to other eligible cores.

Reset
REQ-030 While rst is high, the FSM SHALL be in IDLE with rr_ptr=0, and all outputs SHALL be 0 (gnt, done, done_shared, bus_valid, bus_cmd, bus_addr, mem_req, mem_we).
REQ-031 Reset asserted mid-transaction SHALL abandon it immediately, with no done pulse and no further memory request.
REQ-032 After rst deasserts, arbitration SHALL begin on the first rising edge.

Verification
REQ-033 Single BusRd, no hits: core1 req, cmd 01, addr 0x0000_3000; mem_ack one cycle after mem_req -> bus_valid for 1 cycle with cmd 01 and addr 0x3000, done[1] pulses, done_shared=0.
REQ-034 Shared read: core0 BusRd; snoop_hit=4'b0110 in SNOOP -> done_shared=1; owner bit ignored when snoop_hit=4'b0001 -> done_shared=0.
REQ-035 Dirty intervention: core2 BusRdX; snoop_dirty=4'b1000 -> mem_req with mem_we=1, then mem_we=0 after ack, done[2] with done_shared=0.
REQ-036 Round-robin: req=4'b1111 held continuously -> grant order 0,1,2,3,0; an illegal cmd 11 on core1 -> core1 is skipped.
REQ-037 Reset in MEM: rst pulsed while mem_req=1 -> all outputs 0 at once, no done, and rr_ptr=0 on the next grant.
REQ-038 Back-to-back: core3 done, core3 and core0 both requesting next -> core0 is granted first.

Source files
------------

// File: rtl/mesi_bus_arbiter.sv
// rtl/mesi_bus_arbiter.sv - round-robin snooping bus arbiter for MESI cache controllers
//
// One transaction is outstanding at a time: a winning core's BusRd/BusRdX is
// broadcast for one cycle, the other cores' snoop responses are sampled, a
// dirty copy is written back first if one exists, then memory is read and the
// owner is told whether to install the line Shared or Exclusive/Modified.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req                 per-core request, held until that core's done
//   req_cmd             per-core 2-bit command (01 BusRd, 10 BusRdX)
//   req_addr            per-core line address, ADDR_W bits each
//   gnt                 one-hot owner, ADDR through DONE
//   done, done_shared   one-cycle completion pulse and install-S flag
//   bus_valid/cmd/addr  snooped bus broadcast (ADDR cycle only)
//   snoop_hit/dirty     per-core snoop responses, sampled in SNOOP
//   mem_req, mem_we     memory read (we=0) or writeback (we=1) request
//   mem_ack             completes the current memory request
module mesi_bus_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [2*NUM_CORES-1:0]      req_cmd,
  input  logic [ADDR_W*NUM_CORES-1:0] req_addr,
  output logic [NUM_CORES-1:0]        gnt,
  output logic [NUM_CORES-1:0]        done,
  output logic                        done_shared,
  output logic                        bus_valid,
  output logic [1:0]                  bus_cmd,
  output logic [ADDR_W-1:0]           bus_addr,
  input  logic [NUM_CORES-1:0]        snoop_hit,
  input  logic [NUM_CORES-1:0]        snoop_dirty,
  output logic                        mem_req,
  output logic                        mem_we,
  input  logic                        mem_ack
);

  localparam int IDX_W = (NUM_CORES > 2) ? $clog2(NUM_CORES) : 1;
  localparam logic [1:0] CMD_BUSRD  = 2'b01;
  localparam logic [1:0] CMD_BUSRDX = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_SNOOP = 3'd2,
    S_WB    = 3'd3,
    S_MEM   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     owner;
  logic [1:0]           cmd_q;
  logic [ADDR_W-1:0]    addr_q;
  logic                 shared_q;
  logic [IDX_W-1:0]     rr_ptr;

  logic [NUM_CORES-1:0] eligible;
  logic [NUM_CORES-1:0] owner_oh;
  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic [1:0]           pick_cmd;
  logic [ADDR_W-1:0]    pick_addr;
  logic                 dirty_other;
  logic [IDX_W-1:0]     rr_next;

  assign owner_oh = NUM_CORES'(1) << owner;

  // Snoop responses from the owner itself are meaningless for its own miss.
  assign dirty_other = |(snoop_dirty & ~owner_oh);

  assign rr_next = (owner == IDX_W'(NUM_CORES - 1)) ? '0 : owner + IDX_W'(1);

  // Illegal commands (00/11) make a core invisible to arbitration.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      eligible[i] = req[i] && (req_cmd[2*i +: 2] == CMD_BUSRD ||
                               req_cmd[2*i +: 2] == CMD_BUSRDX);
    end
  end

  // First eligible core at or after rr_ptr, wrapping modulo NUM_CORES.
  always_comb begin
    int k;
    k          = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= NUM_CORES) k = k - NUM_CORES;
      if (!pick_found && eligible[k[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = k[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    pick_cmd  = 2'b00;
    pick_addr = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_cmd  = req_cmd[2*i +: 2];
        pick_addr = req_addr[ADDR_W*i +: ADDR_W];
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Transaction context and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner    <= '0;
      cmd_q    <= 2'b00;
      addr_q   <= '0;
      shared_q <= 1'b0;
      rr_ptr   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            owner    <= pick_idx;
            cmd_q    <= pick_cmd;
            addr_q   <= pick_addr;
            shared_q <= 1'b0;
          end
        end
        S_SNOOP: shared_q <= (cmd_q == CMD_BUSRD) && |(snoop_hit & ~owner_oh);
        S_DONE:  rr_ptr   <= rr_next;
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pick_found) state_nxt = S_ADDR;
      S_ADDR:  state_nxt = S_SNOOP;
      S_SNOOP: state_nxt = dirty_other ? S_WB : S_MEM;
      S_WB:    if (mem_ack) state_nxt = S_MEM;
      S_MEM:   if (mem_ack) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from state only, so reset clears them immediately.
  always_comb begin
    gnt         = '0;
    done        = '0;
    done_shared = 1'b0;
    bus_valid   = 1'b0;
    bus_cmd     = 2'b00;
    bus_addr    = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    case (state)
      S_ADDR: begin
        gnt       = owner_oh;
        bus_valid = 1'b1;
        bus_cmd   = cmd_q;
        bus_addr  = addr_q;
      end
      S_SNOOP: gnt = owner_oh;
      S_WB: begin
        gnt     = owner_oh;
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      S_MEM: begin
        gnt     = owner_oh;
        mem_req = 1'b1;
      end
      S_DONE: begin
        gnt         = owner_oh;
        done        = owner_oh;
        done_shared = shared_q;
      end
      default: ;
    endcase
  end

endmodule
